// File: rtl/msg_wr_arb_pkg.sv
// Shared types and width helpers for the message write arbiter.
// Module parameters default to the values held here.
package msg_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StXfer,
    StDrain,
    StGap,
    StDisp
  } state_e;

  localparam int unsigned N_REQ_DEF   = 2;
  localparam int unsigned DW_DEF      = 8;
  localparam int unsigned GAP_CYC_DEF = 3;
  localparam int unsigned MAX_LEN_DEF = 16;

  // Bits needed to hold the value max_val itself (counters that reach their limit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n entries.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W = cnt_width(MAX_LEN_DEF);
  localparam int unsigned GAP_W = cnt_width(GAP_CYC_DEF);
  localparam int unsigned PTR_W = ptr_width(N_REQ_DEF);

endpackage

// File: rtl/msg_wr_arb_if.sv
// Requester streams plus the character-memory write/display port of the arbiter.
interface msg_wr_arb_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DW    = 8
) ();
  logic [N_REQ-1:0]    req_vld;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ*DW-1:0] req_dat;
  logic [N_REQ-1:0]    req_rdy;
  logic                wr;
  logic [DW-1:0]       dat;
  logic                disp;
  logic [N_REQ-1:0]    gnt;
  logic                busy;
  logic                ovf;

  modport master (
    output req_vld, req_last, req_dat,
    input  req_rdy, wr, dat, disp, gnt, busy, ovf
  );

  modport slave (
    input  req_vld, req_last, req_dat,
    output req_rdy, wr, dat, disp, gnt, busy, ovf
  );
endinterface

// File: rtl/msg_wr_arb_rr_pick.sv
// Combinational round-robin search: first set request at or above the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_found
);

  int w_dist;
  int w_best;

  // Winner is the requester with the smallest wrapped distance from the pointer.
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    w_dist  = 0;
    w_best  = int'(N_REQ);
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_dist = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + int'(N_REQ) - int'(i_ptr);
      if (i_req[i] && (w_dist < w_best)) w_best = w_dist;
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_dist = (i >= int'(i_ptr)) ? i - int'(i_ptr) : i + int'(N_REQ) - int'(i_ptr);
      if (i_req[i] && (w_dist == w_best)) begin
        o_gnt[i] = 1'b1;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_wr_arb.sv
// Round-robin message arbiter: grants one requester per whole message, forwards bytes as
// wr/dat pulses, truncates at MAX_LEN, then waits GAP_CYC idle cycles and pulses disp.
module msg_wr_arb
  import msg_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input logic         clk,
  input logic         rst_b,
  msg_wr_arb_if.slave bus
);

  localparam int unsigned CntW = cnt_width(MAX_LEN);
  localparam int unsigned GapW = cnt_width(GAP_CYC);
  localparam int unsigned PtrW = ptr_width(N_REQ);

  state_e           r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_pick;
  logic             w_found;
  logic [PtrW-1:0]  r_ptr, w_ptr_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [GapW-1:0]  r_gap;
  logic             r_wr, r_disp, r_ovf, r_dropped;
  logic [DW-1:0]    r_dat, w_g_dat;
  logic             w_g_vld, w_g_last, w_open, w_hs;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PtrW)
  ) u_pick (
    .i_req   (bus.req_vld),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick),
    .o_found (w_found)
  );

  // Select the granted stream's byte and the pointer value just past the grant.
  always_comb begin
    w_g_dat   = '0;
    w_ptr_nxt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_gnt[i]) begin
        w_g_dat   = bus.req_dat[i*DW +: DW];
        w_ptr_nxt = (i == int'(N_REQ) - 1) ? '0 : PtrW'(i + 1);
      end
    end
  end

  assign w_g_vld  = |(bus.req_vld & r_gnt);
  assign w_g_last = |(bus.req_last & r_gnt);
  assign w_open   = (r_state == StXfer) || (r_state == StDrain);
  assign w_hs     = w_open && w_g_vld;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_found) w_state_nxt = StXfer;
      StXfer: begin
        if (w_hs) begin
          if (w_g_last)                         w_state_nxt = StGap;
          else if (r_cnt == CntW'(MAX_LEN - 1)) w_state_nxt = StDrain;
        end
      end
      StDrain: if (w_hs && w_g_last) w_state_nxt = StGap;
      StGap:   if (r_gap == GapW'(GAP_CYC)) w_state_nxt = StDisp;
      StDisp:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    bus.req_rdy = w_open ? r_gnt : '0;
    bus.busy    = (r_state != StIdle);
  end

  assign bus.wr   = r_wr;
  assign bus.dat  = r_dat;
  assign bus.disp = r_disp;
  assign bus.gnt  = r_gnt;
  assign bus.ovf  = r_ovf;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_wr      <= 1'b0;
      r_dat     <= '0;
      r_disp    <= 1'b0;
      r_ovf     <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_wr   <= w_hs && (r_state == StXfer);
      r_disp <= (w_state_nxt == StDisp);
      r_ovf  <= w_hs && (r_state == StDrain) && !r_dropped;
      r_gap  <= (r_state == StGap) ? r_gap + 1'b1 : '0;
      // The last byte is still on dat during the first gap cycle; clear it afterwards.
      if (w_hs && (r_state == StXfer)) r_dat <= w_g_dat;
      else if (r_state == StGap)       r_dat <= '0;
      case (r_state)
        StIdle: begin
          r_cnt     <= '0;
          r_dropped <= 1'b0;
          if (w_found) r_gnt <= w_pick;
        end
        StXfer:  if (w_hs) r_cnt <= r_cnt + 1'b1;
        StDrain: if (w_hs) r_dropped <= 1'b1;
        StDisp: begin
          r_gnt <= '0;
          r_ptr <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_wr_arb.sv
// Directed bench for msg_wr_arb: a cycle-exact vector table for one message, then
// scoreboarded sequences for arbitration, overflow, bubbles and asynchronous reset.
module tb_msg_wr_arb;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned DW      = 8;
  localparam int unsigned GAP_CYC = 3;
  localparam int unsigned MAX_LEN = 16;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  msg_wr_arb_if #(.N_REQ(N_REQ), .DW(DW)) bus ();

  msg_wr_arb #(
    .N_REQ   (N_REQ),
    .DW      (DW),
    .GAP_CYC (GAP_CYC),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [7:0] din;
    logic       wr;
    logic [7:0] dat;
    logic       disp;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] rdy;
  } vec_t;

  vec_t vecs [11];

  int         n_chk, n_fail, cyc;
  logic [8:0] q0[$], q1[$];     // {last, byte} per requester
  logic [1:0] hold;
  int         hs_cnt [2];
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  logic [1:0] gnt_log[$];
  logic [1:0] prev_gnt;
  int         disp_cnt, ovf_cnt, ovf_cyc, hs17_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic last, input logic [7:0] din,
                              input logic wr, input logic [7:0] dat, input logic disp,
                              input logic [1:0] gnt, input logic busy, input logic [1:0] rdy);
    vec_t v;
    v.vld = vld; v.last = last; v.din = din; v.wr = wr; v.dat = dat;
    v.disp = disp; v.gnt = gnt; v.busy = busy; v.rdy = rdy;
    return v;
  endfunction

  function automatic logic [14:0] outs();
    return {bus.wr, bus.dat, bus.disp, bus.gnt, bus.busy, bus.req_rdy};
  endfunction

  function automatic logic [31:0] pack_wr();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < wr_log.size() && i < 4; i++) v = {v[23:0], wr_log[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_gnt();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < gnt_log.size() && i < 16; i++) v = {v[29:0], gnt_log[i]};
    return v;
  endfunction

  task automatic drive();
    bus.req_vld  = '0;
    bus.req_last = '0;
    bus.req_dat  = '0;
    if (q0.size() > 0 && !hold[0]) begin
      bus.req_vld[0]     = 1'b1;
      bus.req_last[0]    = q0[0][8];
      bus.req_dat[7:0]   = q0[0][7:0];
    end
    if (q1.size() > 0 && !hold[1]) begin
      bus.req_vld[1]     = 1'b1;
      bus.req_last[1]    = q1[0][8];
      bus.req_dat[15:8]  = q1[0][7:0];
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    gnt_log.delete();
    hs_cnt[0] = 0;
    hs_cnt[1] = 0;
    disp_cnt  = 0;
    ovf_cnt   = 0;
    ovf_cyc   = -1;
    hs17_cyc  = -2;
    prev_gnt  = bus.gnt;
  endtask

  // One clock: capture handshakes before the edge, observe outputs just after it.
  task automatic step();
    logic [1:0] hs;
    logic [8:0] tmp;
    @(negedge clk);
    hs = bus.req_vld & bus.req_rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (hs[0]) begin
      tmp = q0.pop_front();
      hs_cnt[0]++;
      if (hs_cnt[0] == 17) hs17_cyc = cyc;
    end
    if (hs[1]) begin
      tmp = q1.pop_front();
      hs_cnt[1]++;
    end
    if (bus.wr) begin
      wr_log.push_back(bus.dat);
      wr_cyc.push_back(cyc);
    end
    if (bus.disp) disp_cnt++;
    if (bus.ovf) begin
      ovf_cnt++;
      ovf_cyc = cyc;
    end
    if (bus.gnt != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(bus.gnt);
    prev_gnt = bus.gnt;
    drive();
  endtask

  task automatic run_disp(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (disp_cnt < target && n < limit) begin
      step();
      n++;
    end
    check(name, disp_cnt, target);
    step();
    step();
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    q0.delete();
    q1.delete();
    hold = 2'b00;
    drive();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int errs;
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    hold   = 2'b00;

    // "Hello" from requester 0: inputs present at edge k, outputs just after edge k.
    vecs[0]  = mk(1'b1, 1'b0, 8'h48, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b01);
    vecs[1]  = mk(1'b1, 1'b0, 8'h48, 1'b1, 8'h48, 1'b0, 2'b01, 1'b1, 2'b01);
    vecs[2]  = mk(1'b1, 1'b0, 8'h65, 1'b1, 8'h65, 1'b0, 2'b01, 1'b1, 2'b01);
    vecs[3]  = mk(1'b1, 1'b0, 8'h6C, 1'b1, 8'h6C, 1'b0, 2'b01, 1'b1, 2'b01);
    vecs[4]  = mk(1'b1, 1'b0, 8'h6C, 1'b1, 8'h6C, 1'b0, 2'b01, 1'b1, 2'b01);
    vecs[5]  = mk(1'b1, 1'b1, 8'h6F, 1'b1, 8'h6F, 1'b0, 2'b01, 1'b1, 2'b00);
    vecs[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00);
    vecs[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 2'b00);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 2'b01, 1'b1, 2'b00);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0, 2'b00);

    do_reset();
    check("reset_outputs", {outs(), bus.ovf}, 32'h0);

    for (int k = 0; k < 11; k++) begin
      bus.req_vld  = {1'b0, vecs[k].vld};
      bus.req_last = {1'b0, vecs[k].last};
      bus.req_dat  = {8'h00, vecs[k].din};
      @(posedge clk);
      #1;
      check($sformatf("hello_vec%0d", k), outs(),
            {vecs[k].wr, vecs[k].dat, vecs[k].disp, vecs[k].gnt, vecs[k].busy, vecs[k].rdy});
    end

    // Simultaneous requests from reset.
    do_reset();
    q0.push_back(9'h041); q0.push_back(9'h142);
    q1.push_back(9'h043); q1.push_back(9'h144);
    drive();
    run_disp(2, 100, "both_disp_count");
    check("both_wr_count", wr_log.size(), 4);
    check("both_wr_order", pack_wr(), 32'h41424344);
    check("both_gnt_order", pack_gnt(), 32'h6);
    if (wr_cyc.size() >= 3) check("b2b_spacing_ok", (wr_cyc[2] - wr_cyc[1]) >= 5, 1);
    else                    check("b2b_spacing_ok", 0, 1);

    // Fairness under continuous 1-byte requests.
    clear_logs();
    q0.push_back(9'h130); q0.push_back(9'h130);
    q1.push_back(9'h131); q1.push_back(9'h131);
    drive();
    run_disp(4, 200, "fair_disp_count");
    check("fair_gnt_order", pack_gnt(), 32'h66);
    check("fair_wr_order", pack_wr(), 32'h30313031);

    // Overflow: 20-byte message, only the first 16 are written.
    clear_logs();
    for (int i = 0; i < 20; i++) q0.push_back({(i == 19), 8'(8'h60 + i)});
    drive();
    run_disp(1, 200, "ovf_disp_count");
    check("ovf_wr_count", wr_log.size(), 16);
    errs = 0;
    for (int i = 0; i < wr_log.size() && i < 16; i++) if (wr_log[i] !== 8'(8'h60 + i)) errs++;
    check("ovf_wr_data_errs", errs, 0);
    check("ovf_pulse_count", ovf_cnt, 1);
    check("ovf_pulse_timing", ovf_cyc, hs17_cyc);
    check("ovf_all_consumed", hs_cnt[0], 20);

    // Exactly MAX_LEN bytes ending in last: no overflow.
    clear_logs();
    for (int i = 0; i < 16; i++) q0.push_back({(i == 15), 8'(8'h80 + i)});
    drive();
    run_disp(1, 200, "full_disp_count");
    check("full_wr_count", wr_log.size(), 16);
    check("full_no_ovf", ovf_cnt, 0);

    // Bubble: requester 1 (next in round-robin) stalls for 4 cycles mid-message.
    clear_logs();
    q1.push_back(9'h051); q1.push_back(9'h052); q1.push_back(9'h153);
    q0.push_back(9'h150);
    drive();
    n = 0;
    while (hs_cnt[1] < 1 && n < 20) begin
      step();
      n++;
    end
    check("bubble_first_hs", hs_cnt[1], 1);
    hold[1] = 1'b1;
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("bubble_hold%0d", k), {bus.wr, bus.gnt, bus.req_rdy[0], bus.disp},
            {1'b0, 2'b10, 1'b0, 1'b0});
    end
    hold[1] = 1'b0;
    drive();
    run_disp(2, 100, "bubble_disp_count");
    check("bubble_wr_order", pack_wr(), 32'h51525350);
    check("bubble_gnt_order", pack_gnt(), 32'h9);

    // Asynchronous reset mid-message, then arbitration restarts from requester 0.
    clear_logs();
    for (int i = 0; i < 5; i++) q1.push_back({(i == 4), 8'(8'h61 + i)});
    drive();
    n = 0;
    while (hs_cnt[1] < 2 && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_active", {bus.wr, bus.busy, bus.gnt}, 4'b1110);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_reset_outputs", {bus.wr, bus.disp, bus.gnt, bus.busy}, 5'b0);
    q0.delete();
    q1.delete();
    drive();
    @(negedge clk);
    rst_b = 1'b1;
    clear_logs();
    q0.push_back(9'h170);
    q1.push_back(9'h171);
    drive();
    run_disp(2, 100, "post_reset_disp_count");
    check("post_reset_gnt_order", pack_gnt(), 32'h6);
    check("post_reset_wr_order", pack_wr(), 32'h7071);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
